// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared constants and in-flight tag type for the FP multiplier scheduler
//
// Purpose: common widths, the default multiplier latency and the tag struct
//          that records the owner of each operation inside the multiplier.
package fp_mul_pkg;

   localparam int FP_W        = 32;
   localparam int LAT_DEFAULT = 2;

   // Sized for the largest supported requester count (8) so one struct
   // type serves every NREQ; the unused upper id bits simply stay zero.
   localparam int TAG_ID_W = 3;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/fp_rr_arbiter.sv
// rtl/fp_rr_arbiter.sv - combinational round-robin arbiter with gated grant
//
// Purpose: picks the first requester at or after ptr+1 (mod NREQ).
// Ports:
//   req      - request vector
//   ptr      - id of the last accepted requester
//   advance  - grant is only asserted while the consumer can take a pair
//   grant    - one-hot grant (all zero when advance=0 or no request)
//   grant_id - id of the winner (meaningful only when grant is non-zero)
module fp_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id
);

   logic found;

   always_comb begin
      int idx;
      idx      = 0;
      found    = 1'b0;
      grant_id = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            found    = 1'b1;
            grant_id = IDW'(idx);
         end
      end
   end

   always_comb begin
      grant = '0;
      for (int i = 0; i < NREQ; i++) begin
         grant[i] = advance && found && (grant_id == IDW'(i));
      end
   end

endmodule

// File: rtl/fp_mul_scheduler.sv
// rtl/fp_mul_scheduler.sv - round-robin sharing of one pipelined FP multiplier
//
// Purpose: issues at most one operand pair per cycle to an external
//          enable-gated multiplier wrapper, tracks each operation's owner in a
//          tag pipe that moves in lockstep with the wrapper, and steers the
//          result back to its owner with per-requester backpressure.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   req_valid/req_ready/req_a/req_b - per-requester operand handshake (packed 32b lanes)
//   mul_en/mul_a/mul_b             - enable and operands to the wrapper
//   mul_result/mul_of              - wrapper output register and overflow flag
//   rsp_valid/rsp_ready            - per-requester result handshake
//   rsp_result/rsp_of              - shared result bus and overflow flag
//   busy                           - any operation in flight
module fp_mul_scheduler
   import fp_mul_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int LAT  = LAT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*FP_W-1:0] req_a,
   input  logic [NREQ*FP_W-1:0] req_b,
   output logic                 mul_en,
   output logic [FP_W-1:0]      mul_a,
   output logic [FP_W-1:0]      mul_b,
   input  logic [FP_W-1:0]      mul_result,
   input  logic                 mul_of,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [FP_W-1:0]      rsp_result,
   output logic                 rsp_of,
   output logic                 busy
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   tag_t            tag_q [LAT];
   tag_t            out_tag;
   logic [IDW-1:0]  ptr_q;
   logic [IDW-1:0]  grant_id;
   logic [NREQ-1:0] grant;
   logic            accept;
   logic            stall;

   assign out_tag = tag_q[LAT-1];

   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         rsp_valid[i] = out_tag.valid && (out_tag.id == TAG_ID_W'(i));
      end
   end

   // rsp_valid is one-hot when the output tag is valid, so the owner's
   // ready is picked out without indexing by id.
   assign stall  = out_tag.valid & ~|(rsp_valid & rsp_ready);
   assign mul_en = ~stall & ~reset;

   fp_rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req      (req_valid),
      .ptr      (ptr_q),
      .advance  (mul_en),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign accept    = |grant;
   assign req_ready = grant;

   // Grant is already gated by mul_en, so the operand bus idles at zero
   // whenever the wrapper is frozen or nothing is issued.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            mul_a = req_a[FP_W*i +: FP_W];
            mul_b = req_b[FP_W*i +: FP_W];
         end
      end
   end

   assign rsp_result = mul_result;
   assign rsp_of     = out_tag.valid & mul_of;

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         busy = busy | tag_q[i].valid;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= IDW'(NREQ - 1);
      end else if (accept) begin
         ptr_q <= grant_id;
      end
   end

   // Tag pipe advances exactly when the wrapper registers do, keeping each
   // tag aligned with its operation's data.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else if (mul_en) begin
         tag_q[0].valid <= accept;
         tag_q[0].id    <= TAG_ID_W'(grant_id);
         for (int i = 1; i < LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

endmodule
